// File: rtl/lfsr_chk_pkg.sv
// Shared types and helpers for the 3-bit PRBS checker (polynomial 1+x^2+x^3, period 7).
// History/state vectors are ordered {s(n-1), s(n-2), s(n-3)}: tap position k is bit LFSR_W-k.
package lfsr_chk_pkg;

   typedef enum logic {HUNT, LOCKED} chk_state_e;

   localparam int unsigned LFSR_W = 3;
   localparam int unsigned TAP_A  = 1;
   localparam int unsigned TAP_B  = 3;

   // Next stream bit from a 3-bit history: s(n) = s(n-1) ^ s(n-3)
   function automatic logic predict(input logic [LFSR_W-1:0] h);
      return h[LFSR_W-TAP_A] ^ h[LFSR_W-TAP_B];
   endfunction

endpackage

// File: rtl/lfsr3_ref.sv
// Loadable 3-bit Fibonacci reference LFSR. It advances on its own prediction, never on
// received data, so a corrupted input bit cannot propagate into later predictions.
module lfsr3_ref
   import lfsr_chk_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [LFSR_W-1:0] load_val,
   input  logic              adv,
   output logic              pred
);

   logic [LFSR_W-1:0] state;

   assign pred = predict(state);

   // State register: load wins over advance
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= '0;
      end else if (load) begin
         state <= load_val;
      end else if (adv) begin
         state <= {pred, state[LFSR_W-1:1]};
      end
   end

endmodule

// File: rtl/lfsr_prbs_checker.sv
// Self-synchronising PRBS checker for the 3-bit pattern generator stream.
// Optional feature macro: LFSR_PRBS_CHK_RESYNC_EN -- when defined, ERR_LIM errors within an
// ERR_WIN-bit window drop lock and restart the hunt; when undefined, lock is permanent.
module lfsr_prbs_checker
   import lfsr_chk_pkg::*;
#(
   parameter int unsigned LOCK_CNT = 7,
   parameter int unsigned ERR_WIN  = 16,
   parameter int unsigned ERR_LIM  = 4,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Clr,
   input  logic             din,
   input  logic             din_vld,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             lost
);

   localparam int unsigned MW = $clog2(LOCK_CNT + 1);

   chk_state_e        state;
   logic [LFSR_W-1:0] h;
   logic [LFSR_W-1:0] h_next;
   logic [1:0]        fill;
   logic [MW-1:0]     match_cnt;
   logic              hunt_match;
   logic              lock_hit;
   logic              ref_pred;
   logic              mismatch;
   logic              loss;

   // Hunt-side prediction and lock detection for the current bit
   always_comb begin
      h_next     = {din, h[LFSR_W-1:1]};
      hunt_match = (din == predict(h));
      lock_hit   = 1'b0;
      if (state == HUNT && din_vld && fill == 2'd3 && hunt_match && h_next != '0 &&
          match_cnt == MW'(LOCK_CNT - 1)) begin
         lock_hit = 1'b1;
      end
   end

   assign mismatch = din ^ ref_pred;

   lfsr3_ref u_ref (
      .clk      (CLK),
      .rst      (RST),
      .load     (lock_hit),
      .load_val (h_next),
      .adv      (state == LOCKED && din_vld),
      .pred     (ref_pred)
   );

`ifdef LFSR_PRBS_CHK_RESYNC_EN
   localparam int unsigned WCW = (ERR_WIN > 1) ? $clog2(ERR_WIN) : 1;
   localparam int unsigned WEW = $clog2(ERR_LIM + 1);

   logic [WCW-1:0] win_cnt;
   logic [WEW-1:0] win_err;

   // The error that brings win_err up to ERR_LIM is the one that drops lock
   assign loss = (state == LOCKED) && din_vld && mismatch && (win_err == WEW'(ERR_LIM - 1));

   // Observation window: the completing bit belongs to the window, then both counters clear
   always_ff @(posedge CLK) begin
      if (RST) begin
         win_cnt <= '0;
         win_err <= '0;
      end else if (lock_hit) begin
         win_cnt <= '0;
         win_err <= '0;
      end else if (state == LOCKED && din_vld) begin
         if (loss || win_cnt == WCW'(ERR_WIN - 1)) begin
            win_cnt <= '0;
            win_err <= '0;
         end else begin
            win_cnt <= win_cnt + 1'b1;
            if (mismatch) begin
               win_err <= win_err + 1'b1;
            end
         end
      end
   end
`else
   assign loss = 1'b0;

   // Window parameters only matter when resync is built in
   logic unused_win_cfg;
   assign unused_win_cfg = ERR_WIN[0] ^ ERR_LIM[0];
`endif

   // Main FSM with registered outputs; Clr overrides counter increments in the same cycle
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= HUNT;
         h         <= '0;
         fill      <= 2'd0;
         match_cnt <= '0;
         locked    <= 1'b0;
         err       <= 1'b0;
         lost      <= 1'b0;
         err_cnt   <= '0;
         bit_cnt   <= '0;
      end else begin
         err  <= 1'b0;
         lost <= 1'b0;
         if (din_vld) begin
            unique case (state)
               HUNT: begin
                  h <= h_next;
                  if (fill != 2'd3) begin
                     fill <= fill + 2'd1;
                  end else if (lock_hit) begin
                     state     <= LOCKED;
                     locked    <= 1'b1;
                     match_cnt <= '0;
                  end else if (!hunt_match || h_next == '0) begin
                     match_cnt <= '0;
                  end else begin
                     match_cnt <= match_cnt + 1'b1;
                  end
               end
               LOCKED: begin
                  if (mismatch) begin
                     err <= 1'b1;
                     if (err_cnt != '1) begin
                        err_cnt <= err_cnt + 1'b1;
                     end
                  end
                  if (bit_cnt != '1) begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
                  if (loss) begin
                     state     <= HUNT;
                     locked    <= 1'b0;
                     lost      <= 1'b1;
                     fill      <= 2'd0;
                     match_cnt <= '0;
                     h         <= '0;
                  end
               end
               default: ;
            endcase
         end
         if (Clr) begin
            err_cnt <= '0;
            bit_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Bench for lfsr_prbs_checker: directed scenarios with literal expectations, then randomized
// traffic, all compared every cycle against a queue-based model of the stream rules.
module tb_lfsr_prbs_checker;

   localparam int unsigned LOCK_CNT = 7;
   localparam int unsigned ERR_WIN  = 16;
   localparam int unsigned ERR_LIM  = 4;
   localparam int unsigned CNT_W    = 16;
   localparam int          CNT_MAX  = (1 << CNT_W) - 1;
`ifdef LFSR_PRBS_CHK_RESYNC_EN
   localparam bit RESYNC = 1'b1;
`else
   localparam bit RESYNC = 1'b0;
`endif

   logic             CLK = 1'b0;
   logic             RST = 1'b0;
   logic             Clr = 1'b0;
   logic             din = 1'b0;
   logic             din_vld = 1'b0;
   logic             locked;
   logic             err;
   logic             lost;
   logic [CNT_W-1:0] err_cnt;
   logic [CNT_W-1:0] bit_cnt;

   lfsr_prbs_checker #(
      .LOCK_CNT (LOCK_CNT),
      .ERR_WIN  (ERR_WIN),
      .ERR_LIM  (ERR_LIM),
      .CNT_W    (CNT_W)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .Clr     (Clr),
      .din     (din),
      .din_vld (din_vld),
      .locked  (locked),
      .err     (err),
      .err_cnt (err_cnt),
      .bit_cnt (bit_cnt),
      .lost    (lost)
   );

   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Model: hq holds the last received bits (oldest first), rq the ideal continuation
   bit hq[$];
   bit rq[$];
   int m_match, m_win, m_werr;
   bit e_locked, e_err, e_lost;
   int e_errcnt, e_bitcnt;
   bit m_pred;

   always @(posedge CLK) begin
      if (RST) begin
         hq.delete();
         rq.delete();
         m_match = 0; m_win = 0; m_werr = 0;
         e_locked = 0; e_err = 0; e_lost = 0; e_errcnt = 0; e_bitcnt = 0;
      end else begin
         e_err = 0;
         e_lost = 0;
         if (din_vld) begin
            if (!e_locked) begin
               if (hq.size() == 3) begin
                  m_pred  = hq[2] ^ hq[0];
                  m_match = (din == m_pred) ? m_match + 1 : 0;
                  void'(hq.pop_front());
               end
               hq.push_back(din);
               if (hq.size() == 3 && hq[0] == 0 && hq[1] == 0 && hq[2] == 0) m_match = 0;
               if (m_match == LOCK_CNT) begin
                  e_locked = 1;
                  rq = hq;
                  m_match = 0; m_win = 0; m_werr = 0;
               end
            end else begin
               m_pred = rq[2] ^ rq[0];
               void'(rq.pop_front());
               rq.push_back(m_pred);
               if (din != m_pred) begin
                  e_err = 1;
                  if (e_errcnt < CNT_MAX) e_errcnt++;
                  m_werr++;
               end
               if (e_bitcnt < CNT_MAX) e_bitcnt++;
               m_win++;
               if (RESYNC && m_werr >= ERR_LIM) begin
                  e_locked = 0; e_lost = 1;
                  hq.delete();
                  m_match = 0; m_win = 0; m_werr = 0;
               end else if (m_win == ERR_WIN) begin
                  m_win = 0; m_werr = 0;
               end
            end
         end
         if (Clr) begin
            e_errcnt = 0;
            e_bitcnt = 0;
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge CLK) begin
      if (chk_en) begin
         chk("locked", locked, e_locked);
         chk("err", err, e_err);
         chk("lost", lost, e_lost);
         chk("err_cnt", int'(err_cnt), e_errcnt);
         chk("bit_cnt", int'(bit_cnt), e_bitcnt);
      end
   end

   bit pat[7];
   int ph = 0;

   task automatic step(input bit r, input bit c, input bit d, input bit v);
      RST = r; Clr = c; din = d; din_vld = v;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic send(input bit flip, input bit c = 1'b0);
      bit d;
      d  = pat[ph] ^ flip;
      ph = (ph + 1) % 7;
      step(1'b0, c, d, 1'b1);
   endtask

   initial begin
      int lost_seen;
      int rate;
      bit r, c, v, f, d;
      pat = '{0, 0, 1, 1, 1, 0, 1};

      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk_en = 1'b1;
      chk("reset_locked", locked, 0);
      chk("reset_err_cnt", int'(err_cnt), 0);

      // Clean stream from phase 0: lock on the 10th bit, then 20 counted bits
      ph = 0;
      for (int i = 0; i < 9; i++) send(1'b0);
      chk("lock_before_10th", locked, 0);
      send(1'b0);
      chk("lock_at_10th", locked, 1);
      for (int i = 0; i < 20; i++) send(1'b0);
      chk("bit_cnt_20", int'(bit_cnt), 20);
      chk("err_cnt_clean", int'(err_cnt), 0);

      // Single flipped bit
      send(1'b1);
      chk("single_err_pulse", err, 1);
      chk("single_err_cnt", int'(err_cnt), 1);
      for (int i = 0; i < 10; i++) send(1'b0);
      chk("single_err_no_spread", int'(err_cnt), 1);
      chk("single_err_still_locked", locked, 1);

`ifdef LFSR_PRBS_CHK_RESYNC_EN
      // Four errors in one window drop lock, then relock 10 clean bits later
      step(1'b1, 1'b0, 1'b0, 1'b0);
      ph = 3;
      for (int i = 0; i < 10; i++) send(1'b0);
      chk("resync_locked", locked, 1);
      lost_seen = 0;
      for (int i = 0; i < 4; i++) begin
         send(1'b1);
         lost_seen += int'(lost);
      end
      chk("resync_lost_once", lost_seen, 1);
      chk("resync_unlocked", locked, 0);
      for (int i = 0; i < 9; i++) begin
         send(1'b0);
         lost_seen += int'(lost);
      end
      chk("resync_not_yet", locked, 0);
      send(1'b0);
      chk("resync_relocked", locked, 1);
      chk("resync_err_kept", int'(err_cnt), 4);
      chk("resync_lost_total", lost_seen, 1);
`else
      // Lock is permanent: eight errors in one window are only counted
      step(1'b1, 1'b0, 1'b0, 1'b0);
      ph = 3;
      for (int i = 0; i < 10; i++) send(1'b0);
      lost_seen = 0;
      for (int i = 0; i < 8; i++) begin
         send(1'b1);
         lost_seen += int'(lost);
      end
      chk("perm_locked", locked, 1);
      chk("perm_err_cnt", int'(err_cnt), 8);
      chk("perm_no_lost", lost_seen, 0);
`endif

      // All-zero stream never locks
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("zeros_never_lock", locked, 0);

      // din_vld toggling: only valid bits count toward lock
      step(1'b1, 1'b0, 1'b0, 1'b0);
      ph = 5;
      for (int i = 0; i < 20; i++) begin
         if (i % 2 == 0) send(1'b0);
         else step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
         if (i == 16) chk("toggle_9th_valid", locked, 0);
         if (i == 18) chk("toggle_10th_valid", locked, 1);
      end
      chk("toggle_hold", locked, 1);

      // Clr on the same cycle as an error
      send(1'b1, 1'b1);
      chk("clr_err_pulse", err, 1);
      chk("clr_err_cnt", int'(err_cnt), 0);
      chk("clr_bit_cnt", int'(bit_cnt), 0);

      // RST mid-window
      send(1'b1);
      for (int i = 0; i < 3; i++) send(1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      chk("rst_locked", locked, 0);
      chk("rst_err", err, 0);
      chk("rst_lost", lost, 0);
      chk("rst_err_cnt", int'(err_cnt), 0);
      chk("rst_bit_cnt", int'(bit_cnt), 0);

      // Randomized traffic in segments of varying error rate
      for (int seg = 0; seg < 15; seg++) begin
         rate = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 40 : 4);
         for (int i = 0; i < 200; i++) begin
            r = ($urandom_range(0, 299) == 0);
            c = ($urandom_range(0, 79) == 0);
            v = ($urandom_range(0, 3) != 0);
            f = (rate != 0) && ($urandom_range(0, rate - 1) == 0);
            if (v) begin
               d  = pat[ph] ^ f;
               ph = (ph + 1) % 7;
            end else begin
               d = 1'($urandom_range(0, 1));
            end
            step(r, c, d, v);
         end
      end

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/lfsr_prbs_checker.md
# lfsr_prbs_checker

Receive-side companion to the team's 3-bit Fibonacci pattern generator (polynomial 1+x^2+x^3, period 7). It consumes the generator's serial output (the x0 bit stream) after it passes through the circuit under test, self-synchronises to it, and counts bit errors. It sits at the response end of the BIST path and feeds the test controller with lock status and an error count.

## Interface
- LOCK_CNT, 7: consecutive correct predictions required in HUNT before declaring lock.
- ERR_WIN, 16: observation window length, in valid bits, while LOCKED.
- ERR_LIM, 4: errors within one window that declare loss of lock.
- CNT_W, 16: width of err_cnt and bit_cnt.
- CLK  in  1  single clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- Clr  in  1  synchronous clear of err_cnt and bit_cnt only; lock state is kept.
- din  in  1  received serial bit.
- din_vld  in  1  din is sampled only when this is high.
- locked  out  1  high while in LOCKED.
- err  out  1  one-cycle pulse per mismatched bit while LOCKED.
- err_cnt  out  CNT_W  saturating count of errors since reset or Clr.
- bit_cnt  out  CNT_W  saturating count of valid bits checked while LOCKED.
- lost  out  1  one-cycle pulse on the LOCKED to HUNT transition.

## Operation
- Stream recurrence: s(n) = s(n-1) XOR s(n-3), with 3-bit history h = {s(n-1), s(n-2), s(n-3)}.
- Cycles with din_vld=0 change no state. Outputs hold their values and pulses deassert.
- HUNT (reset state):
  - The first 3 valid bits fill h (fill counter 0..3); no comparison is made.
  - Each later valid bit is compared with h[n-1] XOR h[n-3]. A match increments match_cnt; a mismatch clears it.
  - The bit is shifted into h either way.
  - If h becomes 000 after the shift, match_cnt is cleared. The all-zero stream never locks.
  - When match_cnt reaches LOCK_CNT, the state goes to LOCKED. The reference LFSR loads h including the current bit, and win_cnt, win_err and match_cnt clear.
- LOCKED:
  - The reference LFSR predicts each bit from its own state, not from din, so a single error is not multiplied.
  - The reference LFSR advances on every valid bit.
  - A mismatch sets err for one cycle, increments err_cnt (saturating at all-ones) and increments win_err.
  - bit_cnt increments (saturating) on every valid bit.
  - win_cnt counts valid bits 0..ERR_WIN-1. The bit that completes a window is counted in that window; win_cnt and win_err then clear.
  - win_err reaching ERR_LIM (the bit that causes it counts) triggers loss of lock; see Configuration.
- Loss of lock: the state goes to HUNT, lost pulses, and fill, match_cnt and h clear. err_cnt and bit_cnt are kept.
- Clr has priority over an increment in the same cycle: both counters go to 0. err still pulses, and win_err still updates.
- RST returns everything to reset values from any state, including mid-window.

## Timing
- Reset values: locked=0, err=0, lost=0, err_cnt=0, bit_cnt=0. Internal state: HUNT, h=000, all internal counters 0.
- All outputs are registered. err, counter updates and lost appear the cycle after the sampling edge of the causing din.
- Lock latency from reset with a clean stream: locked rises the cycle after the (3+LOCK_CNT)th valid bit, which is the 10th with the default LOCK_CNT.
- The first LOCKED comparison is made on the next valid bit after locked rises.

## Configuration
- LFSR_PRBS_CHK_RESYNC_EN:
  - Defined: reaching ERR_LIM within a window forces HUNT as described in Operation.
  - Undefined: the block stays LOCKED permanently once locked. Window logic is removed, lost is tied to 0, and errors are only counted.

## Structure
- lfsr_chk_pkg holds:
  - the state enum {HUNT, LOCKED};
  - the LFSR width constant (3);
  - the tap constants (positions 1 and 3);
  - a prediction function.
- Sub-module lfsr3_ref: a loadable 3-bit Fibonacci LFSR with load/advance inputs and a predicted-bit output. It is shared with the team's generator taps.

## Test plan
- Clean stream 0,0,1,1,1,0,1 repeated, din_vld=1 constantly, after RST: locked rises after the 10th bit; err stays 0; bit_cnt=20 after 20 further bits.
- Locked, then one bit flipped: a single err pulse, err_cnt=1, no lost, and no further errors on following bits.
- Locked, then 4 flipped bits inside one 16-bit window (RESYNC_EN defined): lost pulses once, locked drops, and the block relocks 10 clean bits later with err_cnt=4 kept.
- Constant 0 input for 50 bits: locked never rises. Same with din_vld toggling 1010: lock timing counts valid bits only, so the 10th valid bit locks.
- Clr asserted on the same cycle as an error: err pulses, err_cnt=0. RST mid-window: all outputs 0 on the next cycle.
- With RESYNC_EN undefined, 8 errors in one window: locked stays 1, err_cnt=8, lost never pulses.
